// File: rtl/char_scan_pkg.sv
// Shared defaults and helpers for the character-grid feature scanner.
package char_scan_pkg;

    localparam int unsigned DEF_ROWS  = 3;
    localparam int unsigned DEF_COLS  = 3;
    localparam int unsigned DEF_CNT_W = 12;
    localparam int unsigned DEF_POS_W = 12;
    localparam int unsigned DEF_TR_W  = 4;

    // Row/column indices never exceed 7, so three bits always suffice.
    localparam int unsigned IDX_W = 3;

    function automatic int unsigned cell_off(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned cols);
        return r * cols + c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/scan_line_trans.sv
// Saturating 0->1 transition counter for one scan line or column.
module scan_line_trans
    import char_scan_pkg::*;
#(
    parameter int unsigned TR_W = DEF_TR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            restart_i,
    input  logic            th_i,
    output logic [TR_W-1:0] count_o
);

    logic            prev_q;
    logic [TR_W-1:0] cnt_q;
    logic            prev_eff;

    // A restart makes the current pixel see a background predecessor.
    assign prev_eff = prev_q & ~restart_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else if (en_i) begin
            prev_q <= th_i;
            if (th_i && !prev_eff)
                cnt_q <= TR_W'(sat_inc(32'(cnt_q), TR_W));
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/char_grid_feature_scan.sv
// Per-cell foreground counts and scan-line transition counts over a
// programmable character box, snapshotted at end of frame.
module char_grid_feature_scan
    import char_scan_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned POS_W = DEF_POS_W,
    parameter int unsigned TR_W  = DEF_TR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_vs,
    input  logic                        i_de,
    input  logic [POS_W-1:0]            i_x,
    input  logic [POS_W-1:0]            i_y,
    input  logic                        i_th,
    input  logic [POS_W-1:0]            cfg_left,
    input  logic [POS_W-1:0]            cfg_right,
    input  logic [POS_W-1:0]            cfg_up,
    input  logic [POS_W-1:0]            cfg_down,
    input  logic [POS_W-1:0]            cfg_cell_w,
    input  logic [POS_W-1:0]            cfg_cell_h,
    input  logic [POS_W-1:0]            cfg_line1,
    input  logic [POS_W-1:0]            cfg_line2,
    input  logic [CNT_W-1:0]            cfg_thresh,
    output logic [ROWS*COLS*CNT_W-1:0]  o_count,
    output logic [ROWS*COLS-1:0]        o_feature,
    output logic [TR_W-1:0]             o_trans_l1,
    output logic [TR_W-1:0]             o_trans_l2,
    output logic [TR_W-1:0]             o_trans_mid,
    output logic                        o_box_err,
    output logic                        o_valid
);

    localparam int unsigned BW = POS_W + 4;

    logic vs_q, low_seen_q, armed_q, snap_q, valid_q;
    logic frame_start, frame_end;

    logic [POS_W-1:0] left_q, right_q, up_q, down_q, line1_q, line2_q, mid_q;
    logic [POS_W-1:0] mid_d;
    logic [CNT_W-1:0] thresh_q;
    logic             box_err_q, box_err_d;
    logic [BW-1:0]    col_bnd_q [COLS];
    logic [BW-1:0]    col_bnd_d [COLS];
    logic [BW-1:0]    row_bnd_q [ROWS];
    logic [BW-1:0]    row_bnd_d [ROWS];

    logic             in_box, qual, pix_on;
    logic [IDX_W-1:0] col_idx, row_idx;
    logic [TR_W-1:0]  tr_l1, tr_l2, tr_mid;
    logic [TR_W-1:0]  tr_l1_q, tr_l2_q, tr_mid_q;
    logic             box_err_out_q;

    // A rise only counts once vs has been seen low since reset, so a frame
    // already in progress at reset release is never measured.
    assign frame_start = i_vs & ~vs_q & low_seen_q;
    assign frame_end   = ~i_vs & vs_q & armed_q;

    always_comb begin
        for (int unsigned c = 0; c < COLS; c++)
            col_bnd_d[c] = {4'b0, cfg_left} + BW'(c) * {4'b0, cfg_cell_w};
        for (int unsigned r = 0; r < ROWS; r++)
            row_bnd_d[r] = {4'b0, cfg_up} + BW'(r) * {4'b0, cfg_cell_h};
    end

    assign box_err_d = (cfg_right <= cfg_left) | (cfg_down <= cfg_up) |
                       (cfg_cell_w == '0) | (cfg_cell_h == '0);
    assign mid_d     = cfg_left + ((cfg_right - cfg_left) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            low_seen_q <= 1'b0;
            armed_q    <= 1'b0;
            snap_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            vs_q       <= i_vs;
            low_seen_q <= low_seen_q | ~i_vs;
            snap_q     <= frame_end;
            valid_q    <= snap_q;
            if (frame_start)
                armed_q <= 1'b1;
            else if (frame_end)
                armed_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q    <= '0;
            right_q   <= '0;
            up_q      <= '0;
            down_q    <= '0;
            line1_q   <= '0;
            line2_q   <= '0;
            mid_q     <= '0;
            thresh_q  <= '0;
            box_err_q <= 1'b0;
            for (int unsigned c = 0; c < COLS; c++) col_bnd_q[c] <= '0;
            for (int unsigned r = 0; r < ROWS; r++) row_bnd_q[r] <= '0;
        end else if (frame_start) begin
            left_q    <= cfg_left;
            right_q   <= cfg_right;
            up_q      <= cfg_up;
            down_q    <= cfg_down;
            line1_q   <= cfg_line1;
            line2_q   <= cfg_line2;
            mid_q     <= mid_d;
            thresh_q  <= cfg_thresh;
            box_err_q <= box_err_d;
            col_bnd_q <= col_bnd_d;
            row_bnd_q <= row_bnd_d;
        end
    end

    assign in_box = (i_x >= left_q) && (i_x < right_q) &&
                    (i_y >= up_q) && (i_y < down_q);
    assign qual   = i_vs & i_de & ~box_err_q & ~frame_start & in_box;
    assign pix_on = qual & i_th;

    // Last boundary not exceeding the coordinate wins; the final cell
    // therefore absorbs any remainder of the box.
    always_comb begin
        col_idx = '0;
        for (int unsigned c = 0; c < COLS; c++)
            if ({4'b0, i_x} >= col_bnd_q[c]) col_idx = IDX_W'(c);
        row_idx = '0;
        for (int unsigned r = 0; r < ROWS; r++)
            if ({4'b0, i_y} >= row_bnd_q[r]) row_idx = IDX_W'(r);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned IDX = cell_off(r, c, COLS);
            logic             hit;
            logic [CNT_W-1:0] cnt_q, hold_q;
            logic             feat_q;

            assign hit = pix_on & (row_idx == IDX_W'(r)) & (col_idx == IDX_W'(c));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    hold_q <= '0;
                    feat_q <= 1'b0;
                end else begin
                    if (snap_q) begin
                        hold_q <= cnt_q;
                        feat_q <= (cnt_q >= thresh_q);
                    end
                    if (frame_start)
                        cnt_q <= '0;
                    else if (hit)
                        cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_W));
                end
            end

            assign o_count[IDX*CNT_W +: CNT_W] = hold_q;
            assign o_feature[IDX]              = feat_q;
        end
    end

    scan_line_trans #(.TR_W(TR_W)) u_trans_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (frame_start),
        .en_i      (qual & (i_y == line1_q)),
        .restart_i (i_x == left_q),
        .th_i      (i_th),
        .count_o   (tr_l1)
    );

    scan_line_trans #(.TR_W(TR_W)) u_trans_l2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (frame_start),
        .en_i      (qual & (i_y == line2_q)),
        .restart_i (i_x == left_q),
        .th_i      (i_th),
        .count_o   (tr_l2)
    );

    scan_line_trans #(.TR_W(TR_W)) u_trans_mid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (frame_start),
        .en_i      (qual & (i_x == mid_q)),
        .restart_i (1'b0),
        .th_i      (i_th),
        .count_o   (tr_mid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_l1_q       <= '0;
            tr_l2_q       <= '0;
            tr_mid_q      <= '0;
            box_err_out_q <= 1'b0;
        end else if (snap_q) begin
            tr_l1_q       <= tr_l1;
            tr_l2_q       <= tr_l2;
            tr_mid_q      <= tr_mid;
            box_err_out_q <= box_err_q;
        end
    end

    assign o_trans_l1  = tr_l1_q;
    assign o_trans_l2  = tr_l2_q;
    assign o_trans_mid = tr_mid_q;
    assign o_box_err   = box_err_out_q;
    assign o_valid     = valid_q;

endmodule

// File: doc/char_grid_feature_scan.md
Name: char_grid_feature_scan

Overview:
- Parametrised successor to the fixed 3x3 digit feature scanner.
- Sits between the binarisation stage and the plate-character classifier.
- Splits a programmable character box into ROWS x COLS cells and counts foreground (i_th) pixels per cell, with saturation.
- Counts 0->1 transitions along two horizontal scan lines and the vertical mid-column. All results are snapshotted at end of frame with a one-cycle valid pulse.

Parameters:
- ROWS, 3, cell rows (1..8)
- COLS, 3, cell columns (1..8)
- CNT_W, 12, per-cell counter width; counters saturate
- POS_W, 12, width of x/y coordinates and box configuration
- TR_W, 4, transition counter width; counters saturate

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- i_vs  in  1  vertical sync; high = active frame
- i_de  in  1  data enable; pixel valid
- i_x  in  POS_W  pixel column
- i_y  in  POS_W  pixel row
- i_th  in  1  binarised pixel; 1 = foreground
- cfg_left, cfg_right  in  POS_W each  box columns, half-open [left,right)
- cfg_up, cfg_down  in  POS_W each  box rows, half-open [up,down)
- cfg_cell_w, cfg_cell_h  in  POS_W each  nominal cell size
- cfg_line1, cfg_line2  in  POS_W each  horizontal scan rows
- cfg_thresh  in  CNT_W  feature threshold
- o_count  out  ROWS*COLS*CNT_W  snapshotted counts; cell (r,c) at index r*COLS+c
- o_feature  out  ROWS*COLS  1 when count >= threshold
- o_trans_l1, o_trans_l2, o_trans_mid  out  TR_W each  transition counts
- o_box_err  out  1  box invalid in the last frame
- o_valid  out  1  one-cycle pulse, results updated

Behaviour:
- Reset: all outputs and internal counters 0; shadow config 0; i_vs history register 0.
- Frame start = rising edge of i_vs, detected against a registered copy of i_vs.
  - Same cycle: all cfg_* latched into shadow registers.
  - Same cycle: all cell and transition counters cleared.
  - cfg changes mid-frame have no effect until the next frame start.
- Box check at frame start: box_err = (right <= left) | (down <= up) | (cell_w == 0) | (cell_h == 0). When set, nothing counts that frame.
- Qualified pixel: i_vs & i_de & !box_err & x in [left,right) & y in [up,down).
- Column index c = largest c in 0..COLS-1 with x >= left + c*cell_w; row index likewise. The last cell absorbs any remainder.
- Index selection is a compare tree against precomputed boundaries; no dividers. Boundaries are computed at POS_W+4 bits so that boundary overflow cannot wrap.
- Count rule: qualified & i_th -> count[r][c]++. Counts saturate at 2^CNT_W-1. One increment per cycle.
- Horizontal transitions, line k (k = 1, 2):
  - On y == line_k, qualified pixels only.
  - prev bit reset to 0 at the first pixel of the box on that line (x == left).
  - Count ++ when i_th == 1 and prev == 0. Saturate at 2^TR_W-1.
- Vertical transitions: mid = left + ((right-left) >> 1), registered at frame start.
  - On qualified pixels with x == mid: count ++ when i_th == 1 and the previous mid pixel was 0.
  - Previous-mid bit reset to 0 at frame start.
- Frame end = falling edge of i_vs.
  - Next cycle: o_count, o_trans_*, o_box_err loaded from the live counters.
  - o_feature[i] = (count_i >= cfg_thresh shadow). The comparison is registered with the snapshot.
  - o_valid = 1 for exactly one cycle, two cycles after the i_vs falling edge (one edge-detect stage, one snapshot stage).
- Outputs hold between snapshots.
- A frame start coincident with a pending snapshot: snapshot wins, then counters clear; no result is lost.
- De-asserting rst_n mid-frame: everything clears; the first snapshot comes after the next complete vs high period.
- A frame with i_de never asserted still snapshots zeros and pulses o_valid.

Decomposition:
- Shared package char_scan_pkg:
  - index helper: cell index -> flattened bus offset
  - saturating-increment function, width-generic
  - defaults for ROWS, COLS, CNT_W, POS_W, TR_W
- Sub-module scan_line_trans (one instance per scan line and mid-column).
  - Inputs: enable, restart, i_th.
  - Output: saturating TR_W transition count.
- Cell counters are generated inline.

Test Plan:
- Solid block: 3x3, box [100,154)x[200,275), cell 18x25, all i_th = 1 -> every count 450, o_feature = 9'h1FF, o_valid is a single pulse 2 cycles after vs falls.
- Remainder cell: box width 58, cell_w 18 -> column 2 spans 22 px. Full fill with box height 75 -> counts for c = 2 are 550, others 450.
- Saturation: CNT_W = 6, 100 foreground pixels in one cell -> count 63. cfg_thresh = 63 -> feature bit 1.
- Transitions: line1 pattern 0011001110 inside box -> o_trans_l1 = 2. Mid-column alternating rows, 75 rows -> o_trans_mid = 38 (TR_W = 8).
- Config shadowing: change cfg_left mid-frame -> the current frame uses the old value; the next frame uses the new one.
- Invalid box: right = left -> all counts 0, o_box_err = 1, o_valid still pulses. Async reset mid-frame -> all outputs 0 immediately.
